// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl
//
// Pointer, flag and output-stage controller for a 129-entry first-word-fall-
// through FIFO built from a bank of WIDTH RAM128X1D distributed-RAM cells.
// The RAM holds up to 128 words; a registered output stage holds one more.
//
// Ports
//   CLK          clock, all state on the rising edge (RAM bank shares it)
//   RST          synchronous active-high reset
//   S_DATA       write data              S_VALID  write request
//   S_READY      RAM has room (registered state only, no path from M_READY)
//   M_DATA       registered read data    M_VALID  M_DATA holds an entry
//   M_READY      consumer accepts M_DATA
//   RAM_WE       write enable to every RAM cell
//   RAM_A        write address           RAM_D    write data, bit i -> cell i
//   RAM_DPRA     read address            RAM_DPO  async read data from cells
//   COUNT        entries held (RAM + output register), 0..129
//   ALMOST_FULL  registered, COUNT >= AF_LEVEL
//   ALMOST_EMPTY registered, COUNT <= AE_LEVEL
module lutram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 120,
  parameter int AE_LEVEL = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             RAM_WE,
  output logic [6:0]       RAM_A,
  output logic [6:0]       RAM_DPRA,
  output logic [WIDTH-1:0] RAM_D,
  input  logic [WIDTH-1:0] RAM_DPO,
  output logic [7:0]       COUNT,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY
);

  localparam logic [7:0] RAM_DEPTH = 8'd128;
  localparam logic [7:0] AF_LVL    = 8'(AF_LEVEL);
  localparam logic [7:0] AE_LVL    = 8'(AE_LEVEL);

  logic [6:0]       wr_ptr_q,   wr_ptr_d;
  logic [6:0]       rd_ptr_q,   rd_ptr_d;
  logic [7:0]       ram_cnt_q,  ram_cnt_d;
  logic             out_vld_q,  out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]       count_q,    count_d;
  logic             af_q,       af_d;
  logic             ae_q,       ae_d;

  logic             s_ready;
  logic             push;
  logic             load;

  always_comb begin
    // Gating with RST keeps the RAM untouched while reset is held.
    s_ready = ~RST & (ram_cnt_q != RAM_DEPTH);
    push    = S_VALID & s_ready;
    // Refill the output register whenever it is empty or being consumed.
    // load needs a word already in RAM, so a push is never bypassed and the
    // read never depends on the RAM's same-address write behaviour.
    load    = (ram_cnt_q != 8'd0) & (~out_vld_q | M_READY);

    wr_ptr_d  = push ? wr_ptr_q + 7'd1 : wr_ptr_q;
    rd_ptr_d  = load ? rd_ptr_q + 7'd1 : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + {7'd0, push} - {7'd0, load};

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = RAM_DPO;
    end else if (M_READY) begin
      out_vld_d  = 1'b0;
    end

    // Flags derive from the next COUNT so all three move on the same edge.
    count_d = ram_cnt_d + {7'd0, out_vld_d};
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      count_q    <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      count_q    <= count_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  assign S_READY      = s_ready;
  assign RAM_WE       = push;
  assign RAM_A        = wr_ptr_q;
  assign RAM_D        = S_DATA;
  assign RAM_DPRA     = rd_ptr_q;
  assign M_DATA       = out_data_q;
  assign M_VALID      = out_vld_q;
  assign COUNT        = count_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Testbench for lutram_fifo_ctrl: a behavioural RAM128X1D bank, a queue-based
// reference FIFO and randomized plus directed traffic.
module tb_lutram_fifo_ctrl;

  localparam int W   = 8;
  localparam int AFL = 120;
  localparam int AEL = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] S_DATA;
  logic         S_VALID;
  logic         S_READY;
  logic [W-1:0] M_DATA;
  logic         M_VALID;
  logic         M_READY;
  logic         RAM_WE;
  logic [6:0]   RAM_A;
  logic [6:0]   RAM_DPRA;
  logic [W-1:0] RAM_D;
  logic [W-1:0] RAM_DPO;
  logic [7:0]   COUNT;
  logic         ALMOST_FULL;
  logic         ALMOST_EMPTY;

  lutram_fifo_ctrl #(.WIDTH(W), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .CLK(CLK), .RST(RST),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DPRA(RAM_DPRA),
    .RAM_D(RAM_D), .RAM_DPO(RAM_DPO),
    .COUNT(COUNT), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
  );

  always #5 CLK = ~CLK;

  // RAM128X1D bank: synchronous write, asynchronous read.
  logic [W-1:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
  assign RAM_DPO = mem[RAM_DPRA];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: words waiting in RAM, the output register, and the
  // plain sequence of accepted words still owed to the consumer.
  logic [W-1:0] ram_q [$];
  logic [W-1:0] owed_q [$];
  logic         m_ov   = 1'b0;
  logic [W-1:0] m_word = '0;

  task automatic step(input logic rst_v, input logic sv, input logic mr, input logic [W-1:0] d);
    logic exp_ready, exp_push, exp_load, popped;
    int   cnt;
    RST = rst_v; S_VALID = sv; M_READY = mr; S_DATA = d;
    #1;
    exp_ready = !rst_v && (ram_q.size() != 128);
    exp_push  = sv && exp_ready;
    exp_load  = (ram_q.size() != 0) && (!m_ov || mr);
    popped    = !rst_v && m_ov && mr;
    chk("s_ready", S_READY, exp_ready);
    chk("ram_we", RAM_WE, exp_push);
    if (popped) begin
      if (owed_q.size() == 0) chk("pop_underflow", 1, 0);
      else chk("pop_order", M_DATA, owed_q.pop_front());
    end
    @(posedge CLK);
    if (rst_v) begin
      ram_q.delete(); owed_q.delete();
      m_ov = 1'b0; m_word = '0;
    end else begin
      if (exp_load) begin
        m_word = ram_q.pop_front();
        m_ov   = 1'b1;
      end else if (mr) begin
        m_ov = 1'b0;
      end
      if (exp_push) begin
        ram_q.push_back(d);
        owed_q.push_back(d);
      end
    end
    #1;
    cnt = ram_q.size() + int'(m_ov);
    chk("m_valid", M_VALID, m_ov);
    chk("m_data", M_DATA, m_word);
    chk("count", COUNT, cnt);
    chk("almost_full", ALMOST_FULL, cnt >= AFL);
    chk("almost_empty", ALMOST_EMPTY, cnt <= AEL);
  endtask

  initial begin
    int k;
    RST = 1'b1; S_VALID = 1'b0; M_READY = 1'b0; S_DATA = '0;
    @(posedge CLK); #1;

    // Reset held with a write request pending, then release.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'hFF);
    chk("reset_count", COUNT, 0);
    chk("reset_ae", ALMOST_EMPTY, 1);
    step(0, 0, 0, 8'h00);

    // Single word latency: valid two edges after acceptance.
    step(0, 1, 1, 8'hA5);
    chk("lat_k1_valid", M_VALID, 0);
    step(0, 0, 1, 8'h00);
    chk("lat_k2_valid", M_VALID, 1);
    chk("lat_k2_data", M_DATA, 8'hA5);
    chk("lat_k2_count", COUNT, 1);
    step(0, 0, 1, 8'h00);
    chk("lat_pop_count", COUNT, 0);

    // Fill with the consumer stalled, then drain.
    for (int i = 0; i < 200; i++) step(0, 1, 0, 8'(i));
    chk("fill_count", COUNT, 129);
    chk("fill_af", ALMOST_FULL, 1);
    for (int i = 0; i < 135; i++) step(0, 0, 1, 8'h00);
    chk("drain_count", COUNT, 0);

    // Full with push and pop offered together.
    k = 0;
    while (COUNT != 8'd129 && k < 300) begin
      step(0, 1, 0, 8'($urandom));
      k++;
    end
    chk("full_reached", COUNT, 129);
    step(0, 1, 1, 8'h77);
    chk("full_sim_count", COUNT, 128);
    chk("full_sim_ready", S_READY, 1);
    for (int i = 0; i < 135; i++) step(0, 0, 1, 8'h00);

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 1000; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    for (int i = 0; i < 135; i++) step(0, 0, 1, 8'h00);
    chk("wrap_drained", COUNT, 0);

    // Reset mid-stream with a push and pop in the same cycle.
    k = 0;
    while (COUNT != 8'd50 && k < 200) begin
      step(0, 1, 0, 8'($urandom));
      k++;
    end
    chk("mid_count50", COUNT, 50);
    step(1, 1, 1, 8'h11);
    chk("mid_rst_count", COUNT, 0);
    chk("mid_rst_valid", M_VALID, 0);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 0, 8'h00);
    chk("mid_first_out", M_DATA, 8'h3C);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
